// File: rtl/load_store_pkg.sv
// Shared definitions for the load/store datapath.
// Holds the funct3 encodings, the load FSM states and the lane count.
package load_store_pkg;

  localparam int BYTE_LANES = 8;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } load_state_t;

  // Illegal funct3 is treated the same as a misaligned access.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [2:0] offset);
    logic bad;
    case (funct3)
      F3_LB, F3_LBU: bad = 1'b0;
      F3_LH, F3_LHU: bad = offset[0];
      F3_LW, F3_LWU: bad = |offset[1:0];
      F3_LD:         bad = |offset;
      default:       bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/load_extract.sv
// Little-endian lane select of an aligned doubleword, followed by
// sign or zero extension according to the load funct3.
module load_extract
  import load_store_pkg::*;
(
  input  logic [63:0] data,
  input  logic [2:0]  addr,
  input  logic [2:0]  funct3,
  output logic [63:0] value
);
  logic [7:0]  lanes [BYTE_LANES];
  logic [7:0]  byte_lo, byte_hi, byte_sel;
  logic [15:0] half_sel;
  logic [31:0] word_sel;

  for (genvar i = 0; i < BYTE_LANES; i++) begin : g_lane
    assign lanes[i] = data[8*i +: 8];
  end

  // Byte select: addr[1:0] picks within each word, addr[2] picks the word.
  mux4 #(.WIDTH(8)) u_byte_lo (
    .sel(addr[1:0]), .d0(lanes[0]), .d1(lanes[1]), .d2(lanes[2]), .d3(lanes[3]), .y(byte_lo)
  );
  mux4 #(.WIDTH(8)) u_byte_hi (
    .sel(addr[1:0]), .d0(lanes[4]), .d1(lanes[5]), .d2(lanes[6]), .d3(lanes[7]), .y(byte_hi)
  );
  mux2 #(.WIDTH(8)) u_byte (
    .sel(addr[2]), .d0(byte_lo), .d1(byte_hi), .y(byte_sel)
  );

  mux4 #(.WIDTH(16)) u_half (
    .sel(addr[2:1]), .d0(data[15:0]), .d1(data[31:16]), .d2(data[47:32]), .d3(data[63:48]),
    .y(half_sel)
  );

  mux2 #(.WIDTH(32)) u_word (
    .sel(addr[2]), .d0(data[31:0]), .d1(data[63:32]), .y(word_sel)
  );

  always_comb begin
    value = '0;
    case (funct3)
      F3_LB:   value = {{56{byte_sel[7]}}, byte_sel};
      F3_LH:   value = {{48{half_sel[15]}}, half_sel};
      F3_LW:   value = {{32{word_sel[31]}}, word_sel};
      F3_LD:   value = data;
      F3_LBU:  value = {56'd0, byte_sel};
      F3_LHU:  value = {48'd0, half_sel};
      F3_LWU:  value = {32'd0, word_sel};
      default: value = '0;
    endcase
  end
endmodule

// File: rtl/mux2.sv
// Two-input multiplexer primitive shared by the load and store lane logic.
module mux2 #(
  parameter int WIDTH = 8
) (
  input  logic             sel,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  output logic [WIDTH-1:0] y
);
  assign y = sel ? d1 : d0;
endmodule

// File: rtl/mux4.sv
// Four-input multiplexer primitive shared by the load and store lane logic.
module mux4 #(
  parameter int WIDTH = 8
) (
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  output logic [WIDTH-1:0] y
);
  always_comb begin
    case (sel)
      2'd0:    y = d0;
      2'd1:    y = d1;
      2'd2:    y = d2;
      default: y = d3;
    endcase
  end
endmodule

// File: rtl/load_unit.sv
// Single-outstanding load unit: issues an aligned doubleword read, then
// returns the extended lane to writeback as a one-cycle result.
module load_unit
  import load_store_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [XLEN-1:0] ld_addr,
  input  logic [2:0]      ld_funct3,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_rsp_valid,
  input  logic [XLEN-1:0] mem_rsp_data,
  output logic            res_valid,
  output logic [XLEN-1:0] res_data,
  output logic            res_misaligned
);
  load_state_t     state;
  logic [XLEN-1:0] addr_q;
  logic [2:0]      funct3_q;
  logic [XLEN-1:0] ext_value;

  // Handshake outputs decode straight from the state register, so an
  // asynchronous reset drops the request and reopens the input at once.
  assign ld_ready      = (state == IDLE);
  assign mem_req_valid = (state == REQ);
  assign res_valid     = (state == DONE);
  assign mem_req_addr  = {addr_q[XLEN-1:3], 3'b000};

  load_extract u_extract (
    .data  (mem_rsp_data),
    .addr  (addr_q[2:0]),
    .funct3(funct3_q),
    .value (ext_value)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      addr_q         <= '0;
      funct3_q       <= '0;
      res_data       <= '0;
      res_misaligned <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ld_valid) begin
            addr_q   <= ld_addr;
            funct3_q <= ld_funct3;
            if (is_misaligned(ld_funct3, ld_addr[2:0])) begin
              res_data       <= '0;
              res_misaligned <= 1'b1;
              state          <= DONE;
            end else begin
              state <= REQ;
            end
          end
        end
        REQ: begin
          if (mem_req_ready) state <= WAIT;
        end
        WAIT: begin
          if (mem_rsp_valid) begin
            res_data       <= ext_value;
            res_misaligned <= 1'b0;
            state          <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/load_unit.md
Name: load_unit

Overview:
- Read-side counterpart of the store/write datapath.
- Accepts one load request (byte address plus RV64 load funct3) and issues a doubleword-aligned read to data memory over a valid/ready request channel.
- Waits for the read response, extracts the addressed byte/half/word/doubleword lane (little-endian), sign- or zero-extends it to 64 bits, and returns a registered one-cycle result to the writeback stage.
- Misaligned or illegal loads are flagged without touching memory.

Parameters:
- XLEN, 64, data and address width; the lane logic is fixed at 8 byte lanes.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- ld_valid  in  1  load request present
- ld_ready  out  1  unit can accept a request
- ld_addr  in  XLEN  byte address of the load
- ld_funct3  in  3  000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU, 111 illegal
- mem_req_valid  out  1  memory read request valid
- mem_req_ready  in  1  memory accepts the request
- mem_req_addr  out  XLEN  {ld_addr[XLEN-1:3], 3'b000}
- mem_rsp_valid  in  1  read data valid
- mem_rsp_data  in  XLEN  aligned doubleword read from memory
- res_valid  out  1  result valid, one-cycle pulse
- res_data  out  XLEN  extended load result
- res_misaligned  out  1  misaligned access or illegal funct3

Behaviour:
- Reset value of every output register and of the state is 0; after reset the FSM is in IDLE, so ld_ready = 1.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - ld_ready = 1.
  - On ld_valid, capture ld_addr and ld_funct3 into internal registers.
  - If the access is misaligned (LH/LHU with addr[0] = 1; LW/LWU with addr[1:0] ≠ 0; LD with addr[2:0] ≠ 0) or funct3 = 111, go to DONE with the fault flag set.
  - Otherwise go to REQ.
- REQ:
  - mem_req_valid = 1.
  - mem_req_addr is driven from the captured address and is held stable until the handshake completes.
  - On mem_req_valid && mem_req_ready, go to WAIT.
- WAIT:
  - On mem_rsp_valid, register the extracted and extended data and go to DONE.
  - mem_rsp_valid is ignored in every other state.
- DONE:
  - res_valid = 1 for exactly one cycle, then return to IDLE.
  - On a fault: res_data = 0 and res_misaligned = 1.
  - On success: res_misaligned = 0.
  - ld_ready = 0 in DONE; back-to-back loads have a one-cycle gap.
- Latency:
  - Accept at cycle 0, request at cycle 1.
  - With mem_req_ready = 1 and a response at cycle 2, res_valid rises at cycle 3.
  - Faulted loads: res_valid at cycle 1, and mem_req_valid is never asserted.
- Lane extraction and extension:
  - byte = data[8*a +: 8] with a = addr[2:0].
  - half = data[16*a[2:1] +: 16].
  - word = data[32*a[2] +: 32].
  - LB/LH/LW sign-extend; LBU/LHU/LWU zero-extend; LD passes the data through.
- res_data and res_misaligned hold their last value outside DONE; they are qualified only by res_valid.
- Reset mid-operation (REQ or WAIT):
  - The request is dropped immediately and the FSM returns to IDLE.
  - A later mem_rsp_valid is ignored until the next REQ/WAIT cycle.
- Only one outstanding request; no queueing.

Decomposition:
- Shared package load_store_pkg:
  - funct3 constants (F3_LB … F3_LWU).
  - FSM state encoding.
  - Byte-lane count constant.
- Sub-module load_extract: purely combinational lane select and sign/zero extension (inputs data, addr[2:0], funct3; output 64-bit value).
  - Built from the existing mux2/mux4 primitives so the read-side lane select mirrors the write path.
  - The FSM and registers stay in load_unit.

Test Plan:
- LB: ld_addr = 0x1005, mem_rsp_data = 0xF0E0D0C0B0A09080 → mem_req_addr = 0x1000, res_data = 0xFFFFFFFFFFFFFFD0, res_misaligned = 0, res_valid at cycle 3 with mem_req_ready tied high.
- LBU at 0x1005 → 0x00000000000000D0. LH at 0x1002 → 0xFFFFFFFFFFFFB0A0. LWU at 0x1004 → 0x00000000F0E0D0C0. LD at 0x1000 → 0xF0E0D0C0B0A09080.
- LD at 0x1004 (misaligned), then funct3 = 111 at 0x1000 → res_valid one cycle after accept, res_misaligned = 1, res_data = 0, mem_req_valid stays 0 throughout.
- Backpressure: mem_req_ready low for 3 cycles → mem_req_valid held 1 with mem_req_addr stable, exactly one accepted request, ld_ready = 0 until DONE completes.
- Stray response: mem_rsp_valid pulsed while in IDLE → no res_valid. Then a normal LW at 0x1000 with mem_rsp_data = 0x00000000_8000_0001 → res_data = 0xFFFFFFFF80000001.
- Reset asserted asynchronously during WAIT → mem_req_valid = 0, res_valid = 0, ld_ready = 1 immediately. A response arriving after reset → no res_valid. The next load completes normally.
